// File: rtl/apu_decimation_filter_pkg.sv
// Shared types, widths and the 64-tap lowpass coefficient set of the APU filters.
// The same table feeds the 16x interpolator and the 16:1 decimator.
package apu_decimation_filter_pkg;

  localparam int unsigned W_SAMPLE     = 16;
  localparam int unsigned W_COEFF      = 9;
  localparam int unsigned W_ACC        = 32;
  localparam int unsigned SHIFT        = 12;
  localparam int unsigned TAPS         = 64;
  localparam int unsigned PHASES       = 16;
  localparam int unsigned BRANCHES     = TAPS / PHASES;
  localparam int unsigned W_PHASE      = $clog2(PHASES);
  localparam int unsigned W_BRANCH     = $clog2(BRANCHES);
  localparam int unsigned W_BLANK      = 2;
  localparam int unsigned BLANK_BLOCKS = 3;

  typedef logic signed [W_SAMPLE-1:0] sample_t;
  typedef logic signed [W_COEFF-1:0]  coeff_t;
  typedef logic signed [W_ACC-1:0]    acc_t;

  // Symmetric about h[31]; h[63] pads the set to 4 x 16. Sum 3560, sum|h| 3892.
  localparam coeff_t H [TAPS] = '{
    -9'sd1,  -9'sd2,  -9'sd3,  -9'sd4,  -9'sd5,  -9'sd6,  -9'sd7,  -9'sd8,
    -9'sd8,  -9'sd8,  -9'sd8,  -9'sd7,  -9'sd6,  -9'sd5,  -9'sd5,   9'sd9,
     9'sd12,  9'sd24,  9'sd38,  9'sd53,  9'sd70,  9'sd90,  9'sd107, 9'sd124,
     9'sd140, 9'sd155, 9'sd168, 9'sd180, 9'sd190, 9'sd198, 9'sd203, 9'sd204,
     9'sd203, 9'sd198, 9'sd190, 9'sd180, 9'sd168, 9'sd155, 9'sd140, 9'sd124,
     9'sd107, 9'sd90,  9'sd70,  9'sd53,  9'sd38,  9'sd24,  9'sd12,  9'sd9,
    -9'sd5,  -9'sd5,  -9'sd6,  -9'sd7,  -9'sd8,  -9'sd8,  -9'sd8,  -9'sd8,
    -9'sd7,  -9'sd6,  -9'sd5,  -9'sd4,  -9'sd3,  -9'sd2,  -9'sd1,   9'sd0
  };

endpackage

// File: rtl/apu_decimation_filter_if.sv
// Sample stream bus of the decimator: oversampled input side, 48 kHz output side.
interface apu_decimation_filter_if;
  import apu_decimation_filter_pkg::*;

  logic    in_valid;
  sample_t in_data;
  logic    out_valid;
  sample_t out_data;

  modport master (output in_valid, output in_data, input out_valid, input out_data);
  modport slave  (input in_valid, input in_data, output out_valid, output out_data);
endinterface

// File: rtl/apu_decimation_filter_mac.sv
// Polyphase tap lookup and four parallel signed products for the sample at phase p.
module apu_decim_mac
  import apu_decimation_filter_pkg::*;
(
  input  logic [W_PHASE-1:0] phase,
  input  sample_t            x,
  output coeff_t             coeff_c [BRANCHES],
  output acc_t               prod_c  [BRANCHES]
);

  // Branch b uses tap 16b + 15 - p, i.e. {b, ~p}.
  always_comb begin
    for (int b = 0; b < int'(BRANCHES); b++) begin
      coeff_c[b] = H[{W_BRANCH'(b), ~phase}];
      prod_c[b]  = W_ACC'(x) * W_ACC'(coeff_c[b]);
    end
  end

endmodule

// File: rtl/apu_decimation_filter.sv
// 16:1 decimating 64-tap FIR, four staggered accumulators, blanked for 3 blocks after restart.
// Define APU_DECIM_ROUND_EN for round-half-up output scaling; otherwise the shift floors.
module apu_decimation_filter
  import apu_decimation_filter_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  input logic                  clr,
  apu_decimation_filter_if.slave bus
);

`ifdef APU_DECIM_ROUND_EN
  localparam acc_t ROUND = acc_t'(2 ** (SHIFT - 1));
`else
  localparam acc_t ROUND = acc_t'(0);
`endif

  logic [W_PHASE-1:0] phase;
  logic [W_BLANK-1:0] blank;
  acc_t               acc [BRANCHES];
  coeff_t             coeff_unused_c [BRANCHES];
  acc_t               prod_c [BRANCHES];
  acc_t               total_c;
  logic               block_end_c;
  logic               unused_bits_c;

  apu_decim_mac u_mac (
    .phase   (phase),
    .x       (bus.in_data),
    .coeff_c (coeff_unused_c),
    .prod_c  (prod_c)
  );

  assign block_end_c = bus.in_valid && (phase == W_PHASE'(PHASES - 1));
  assign total_c     = acc[0] + prod_c[0] + ROUND;
  // Gain below 4096 keeps the scaled result inside 16 bits; the rest is discarded.
  assign unused_bits_c = ^{total_c[SHIFT-1:0], total_c[W_ACC-1:SHIFT+W_SAMPLE]};

  always_ff @(posedge clk) begin
    if (rst) begin
      phase         <= '0;
      blank         <= W_BLANK'(BLANK_BLOCKS);
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      for (int b = 0; b < int'(BRANCHES); b++) acc[b] <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      if (clr) begin
        phase <= '0;
        blank <= W_BLANK'(BLANK_BLOCKS);
        for (int b = 0; b < int'(BRANCHES); b++) acc[b] <= '0;
      end else if (bus.in_valid) begin
        phase <= phase + 1'b1;
        if (block_end_c) begin
          // Each partial output moves one block closer to completion.
          for (int b = 0; b < int'(BRANCHES) - 1; b++) acc[b] <= acc[b+1] + prod_c[b+1];
          acc[BRANCHES-1] <= '0;
          if (blank != '0) begin
            blank <= blank - 1'b1;
          end else begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= sample_t'(total_c[SHIFT +: W_SAMPLE]);
          end
        end else begin
          for (int b = 0; b < int'(BRANCHES); b++) acc[b] <= acc[b] + prod_c[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_apu_decimation_filter.sv
// Directed bench for apu_decimation_filter: DC, impulse, extremes, gapped input, clr and rst.
module tb_apu_decimation_filter;
  import apu_decimation_filter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   tests  = 0;
  int   failed = 0;
  int   pulses = 0;
  int   cyc    = 0;
  int   prev_cyc = 0;
  int   last_gap = 0;
  int   base;

  apu_decimation_filter_if bus ();

  apu_decimation_filter dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Counts out_valid strobes and the cycle distance between consecutive ones.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      pulses++;
      last_gap = cyc - prev_cyc;
      prev_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic push_n(input sample_t x, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      tick();
      bus.in_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    clr = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    rst = 1'b0;

    // DC 0x1000: sum(h) * 4096 >> 12 = 3560 = 0x0DE8
    base = pulses;
    push_n(16'sh1000, 48, 0);
    settle();
    check("dc_blanked", pulses - base, 0);
    push_n(16'sh1000, 32, 0);
    settle();
    check("dc_count", pulses - base, 2);
    check("dc_data", 32'(bus.out_data), 32'sh0DE8);
    check("dc_spacing", last_gap, 16);

    // Impulse at phase 0 of block 3 walks h[15], h[31], h[47], h[63]
    do_reset();
    base = pulses;
    push_n(16'sh0000, 48, 0);
    push_n(16'sh1000, 1, 0);
    push_n(16'sh0000, 15, 0);
    settle();
    check("imp_count0", pulses - base, 1);
    check("imp_out0", 32'(bus.out_data), 32'sh0009);
    push_n(16'sh0000, 16, 0);
    settle();
    check("imp_out1", 32'(bus.out_data), 32'sh00CC);
    push_n(16'sh0000, 16, 0);
    settle();
    check("imp_out2", 32'(bus.out_data), 32'sh0009);
    push_n(16'sh0000, 16, 0);
    settle();
    check("imp_out3", 32'(bus.out_data), 32'sh0000);
    check("imp_count3", pulses - base, 4);

    // DC 2: 7120 / 4096 = 1.74
    do_reset();
    push_n(16'sh0002, 64, 0);
    settle();
`ifdef APU_DECIM_ROUND_EN
    check("dc2_data", 32'(bus.out_data), 2);
`else
    check("dc2_data", 32'(bus.out_data), 1);
`endif

    // Full-scale negative DC: -32768 * 3560 >> 12 = -28480
    do_reset();
    push_n(-16'sh8000, 64, 0);
    settle();
    check("dcneg_data", 32'(bus.out_data), -32'sd28480);

    // One sample every 3 cycles
    do_reset();
    base = pulses;
    push_n(16'sh1000, 80, 2);
    settle();
    check("gap_count", pulses - base, 2);
    check("gap_data", 32'(bus.out_data), 32'sh0DE8);
    check("gap_spacing", last_gap, 48);

    // clr at phase 7 with a concurrent sample that must be dropped
    push_n(16'sh1000, 7, 0);
    clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sh7FFF;
    tick();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_hold_data", 32'(bus.out_data), 32'sh0DE8);
    check("clr_out_valid", 32'(bus.out_valid), 0);
    base = pulses;
    push_n(16'sh1000, 63, 0);
    settle();
    check("clr_blank", pulses - base, 0);
    push_n(16'sh1000, 1, 0);
    settle();
    check("clr_first_out", pulses - base, 1);
    check("clr_data", 32'(bus.out_data), 32'sh0DE8);

    // rst and clr together mid-block
    push_n(16'sh1000, 5, 0);
    rst = 1'b1;
    clr = 1'b1;
    tick();
    rst = 1'b0;
    clr = 1'b0;
    check("rstclr_data", 32'(bus.out_data), 0);
    check("rstclr_valid", 32'(bus.out_valid), 0);
    base = pulses;
    push_n(16'sh1000, 48, 0);
    settle();
    check("rstclr_blank", pulses - base, 0);
    push_n(16'sh1000, 16, 0);
    settle();
    check("rstclr_count", pulses - base, 1);
    check("rstclr_out", 32'(bus.out_data), 32'sh0DE8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
